ball_split_ctrl: RTL
====================

Name: ball_split_ctrl

Overview:
Slot scheduler and configurator for up to NUM_BALLS ball-trajectory instances in the game datapath. It tracks which ball slots are active and each slot's size. On a rope hit it either kills the ball (smallest size) or splits it into two children one size smaller. Children are launched in opposite X directions with an upward kick, loaded into slots through a shared load bus. Sits between the collision logic and the per-slot ball-movement instances.

Parameters:
NUM_BALLS, 4, number of ball slots (power of 2, max 8)
MAX_SIZE, 2, size of the initially spawned ball; size 0 is smallest
INITIAL_X, 26, spawn X in pixels
INITIAL_Y, 26, spawn Y in pixels
INITIAL_X_SPEED, 100, spawn X speed in 1/64-pixel-per-frame units
SPLIT_X_SPEED, 64, child X speed magnitude in 1/64 units
SPLIT_Y_SPEED, 200, child upward speed magnitude in 1/64 units (loaded negative)
RESPAWN_FRAMES, 60, frames between level clear and respawn

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
startOfFrame  in  1  one-clk pulse per frame
hitValid  in  1  one-clk pulse: rope hit a ball
hitIdx  in  $clog2(NUM_BALLS)  slot that was hit
hitX  in  11  hit ball top-left X, pixels
hitY  in  11  hit ball top-left Y, pixels
loadValid  out  1  one-clk pulse: slot loadIdx must adopt the load values
loadIdx  out  $clog2(NUM_BALLS)  target slot
loadX  out  11  position X, pixels
loadY  out  11  position Y, pixels
loadXSpeed  out  11 signed  X speed, 1/64 units
loadYSpeed  out  11 signed  Y speed, 1/64 units
active  out  NUM_BALLS  per-slot enable for drawing and collision
sizes  out  2*NUM_BALLS  per-slot size; slot i uses bits [2i+1:2i]
busy  out  1  high whenever state != IDLE
levelClear  out  1  one-clk pulse when the last ball dies

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state=SPAWN; active=0; sizes=0; loadValid=0; loadIdx=0; loadX/Y/speeds=0; levelClear=0; frame counter=0.
- SPAWN (one cycle):
  - loadValid=1, loadIdx=0, loadX=INITIAL_X, loadY=INITIAL_Y, loadXSpeed=INITIAL_X_SPEED, loadYSpeed=0.
  - active[0]<=1, sizes[0]<=MAX_SIZE; next state IDLE.
- IDLE:
  - A hit is accepted only when hitValid=1 and active[hitIdx]=1. Otherwise it is ignored.
  - Hits arriving while busy=1 are dropped; there is no queue.
  - Accepted hit: latch hitIdx/hitX/hitY.
  - If sizes[hitIdx]==0, go to KILL. Otherwise go to SPLIT_A.
  - The lowest-index free slot (active==0) is latched in the same cycle.
- SPLIT_A (one cycle):
  - Load slot hitIdx at (hitX,hitY) with X speed -SPLIT_X_SPEED and Y speed -SPLIT_Y_SPEED.
  - sizes[hitIdx]<=size-1.
- SPLIT_B (one cycle):
  - If a free slot was found: load it at (hitX,hitY) with speeds +SPLIT_X_SPEED / -SPLIT_Y_SPEED.
  - Set its active bit and sizes to the child size.
  - If no free slot: loadValid=0 and the second child is discarded.
  - Next state IDLE.
- Split latency: hit accepted in cycle n, load pulses in n+1 (slot A) and n+2 (slot B), IDLE again in n+3.
- KILL (one cycle):
  - active[hitIdx]<=0.
  - If the resulting active vector is 0: levelClear=1 this cycle, clear the frame counter, go to WAIT. Otherwise go to IDLE.
- WAIT:
  - Count startOfFrame pulses.
  - At count==RESPAWN_FRAMES-1 together with a startOfFrame pulse, go to SPAWN.
  - No hits are possible here because all slots are inactive.
- Free-slot search is a combinational priority encoder over ~active. The lowest index wins.
- Speeds are formed as 11-bit two's complement. Parameters must fit in the range −1024..1023.
- Reset mid-operation: all state is abandoned and SPAWN is re-entered. A load in flight is not completed.
- hitValid together with startOfFrame has no interaction; startOfFrame is used only in WAIT.

Decomposition:
- Package ball_pkg:
  - typedef enum state_t {SPAWN, IDLE, SPLIT_A, SPLIT_B, KILL, WAIT}
  - typedef logic [1:0] ball_size_t
  - localparam SPEED_W=11, POS_W=11, MULTIPLIER=64
- One sub-module: ball_free_slot_finder (priority encoder).
  - Inputs: active vector.
  - Outputs: found flag and the lowest free index.

Test Plan:
- Release reset, no hits -> single loadValid cycle after reset with loadIdx=0, X=26, Y=26, XSpeed=100, YSpeed=0; active=0001, sizes slot0=2.
- After spawn, hitValid idx0 at X=300, Y=200 -> cycle n+1: load idx0 XSpeed −64 YSpeed −200; cycle n+2: load idx1 XSpeed +64 YSpeed −200; active=0011, both sizes=1.
- Split down to size 0, then hit a size-0 ball while others remain -> no load pulse, that active bit clears, levelClear stays 0.
- All 4 slots active, hit a size-1 ball -> only the slot-A load occurs; SPLIT_B emits loadValid=0; active unchanged at 1111.
- Kill the last ball -> levelClear pulse; respawn load (idx0, 26, 26) occurs exactly after the 60th startOfFrame; hitValid on an inactive index is ignored.
- hitValid asserted during busy=1, and reset asserted during SPLIT_A -> busy hit is dropped; reset immediately clears outputs, then SPAWN is replayed.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared types and constants for the ball split controller and its slot datapath.
package ball_pkg;

    typedef enum logic [2:0] {SPAWN, IDLE, SPLIT_A, SPLIT_B, KILL, WAIT} state_t;
    typedef logic [1:0] ball_size_t;

    localparam int SPEED_W    = 11;
    localparam int POS_W      = 11;
    localparam int MULTIPLIER = 64;

    // Largest magnitude a speed field can carry: 16 px/frame in 1/MULTIPLIER units.
    localparam int SPEED_LIMIT = 16 * MULTIPLIER - 1;

    function automatic logic signed [SPEED_W-1:0] to_speed(input int v);
        int c;
        c = v;
        if (c > SPEED_LIMIT)
            c = SPEED_LIMIT;
        else if (c < -SPEED_LIMIT - 1)
            c = -SPEED_LIMIT - 1;
        return c[SPEED_W-1:0];
    endfunction

endpackage

// File: rtl/ball_split_ctrl_if.sv
// Hit input and slot load bus between collision logic, the controller and ball slots.
interface ball_split_ctrl_if #(
    parameter int NUM_BALLS = 4
);
    import ball_pkg::*;

    localparam int IDX_W = $clog2(NUM_BALLS);

    logic                       hitValid;
    logic [IDX_W-1:0]           hitIdx;
    logic [POS_W-1:0]           hitX;
    logic [POS_W-1:0]           hitY;

    logic                       loadValid;
    logic [IDX_W-1:0]           loadIdx;
    logic [POS_W-1:0]           loadX;
    logic [POS_W-1:0]           loadY;
    logic signed [SPEED_W-1:0]  loadXSpeed;
    logic signed [SPEED_W-1:0]  loadYSpeed;

    modport master (
        input  hitValid, hitIdx, hitX, hitY,
        output loadValid, loadIdx, loadX, loadY, loadXSpeed, loadYSpeed
    );

    modport slave (
        output hitValid, hitIdx, hitX, hitY,
        input  loadValid, loadIdx, loadX, loadY, loadXSpeed, loadYSpeed
    );

endinterface

// File: rtl/ball_free_slot_finder.sv
// Priority encoder returning the lowest-index inactive ball slot.
module ball_free_slot_finder #(
    parameter int NUM_BALLS = 4
) (
    input  logic [NUM_BALLS-1:0]         active,
    output logic                         found,
    output logic [$clog2(NUM_BALLS)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_BALLS);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_BALLS; i++) begin
            if (!active[i] && !found) begin
                found = 1'b1;
                idx   = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ball_split_ctrl.sv
// Ball slot scheduler: spawns the first ball, splits or kills balls on rope hits,
// and respawns after a level clear.
module ball_split_ctrl
    import ball_pkg::*;
#(
    parameter int NUM_BALLS       = 4,
    parameter int MAX_SIZE        = 2,
    parameter int INITIAL_X       = 26,
    parameter int INITIAL_Y       = 26,
    parameter int INITIAL_X_SPEED = 100,
    parameter int SPLIT_X_SPEED   = 64,
    parameter int SPLIT_Y_SPEED   = 200,
    parameter int RESPAWN_FRAMES  = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    ball_split_ctrl_if.master      bus,
    output logic [NUM_BALLS-1:0]   active,
    output logic [2*NUM_BALLS-1:0] sizes,
    output logic                   busy,
    output logic                   levelClear
);

    localparam int IDX_W = $clog2(NUM_BALLS);
    localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);

    localparam logic signed [SPEED_W-1:0] SPAWN_XS = to_speed(INITIAL_X_SPEED);
    localparam logic signed [SPEED_W-1:0] LEFT_XS  = to_speed(-SPLIT_X_SPEED);
    localparam logic signed [SPEED_W-1:0] RIGHT_XS = to_speed(SPLIT_X_SPEED);
    localparam logic signed [SPEED_W-1:0] UP_YS    = to_speed(-SPLIT_Y_SPEED);

    state_t             state, state_n;
    ball_size_t         size_q [NUM_BALLS];
    logic [IDX_W-1:0]   hit_idx_q;
    logic [POS_W-1:0]   hit_x_q, hit_y_q;
    ball_size_t         child_size_q;
    logic               free_found_q;
    logic [IDX_W-1:0]   free_idx_q;
    logic [CNT_W-1:0]   frame_cnt;

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               hit_ok;
    ball_size_t         hit_size;
    logic [NUM_BALLS-1:0] remaining;
    logic               last_frame;

    ball_free_slot_finder #(
        .NUM_BALLS(NUM_BALLS)
    ) u_free (
        .active(active),
        .found (free_found),
        .idx   (free_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= SPAWN;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        hit_ok     = bus.hitValid && active[bus.hitIdx];
        hit_size   = size_q[bus.hitIdx];
        remaining  = active & ~(NUM_BALLS'(1) << hit_idx_q);
        last_frame = startOfFrame && (frame_cnt == CNT_W'(RESPAWN_FRAMES - 1));
        levelClear = 1'b0;
        busy       = (state != IDLE);
        case (state)
            SPAWN:   state_n = IDLE;
            IDLE:    if (hit_ok) state_n = (hit_size == '0) ? KILL : SPLIT_A;
            SPLIT_A: state_n = SPLIT_B;
            SPLIT_B: state_n = IDLE;
            KILL: begin
                levelClear = (remaining == '0);
                state_n    = (remaining == '0) ? WAIT : IDLE;
            end
            WAIT:    if (last_frame) state_n = SPAWN;
            default: state_n = SPAWN;
        endcase
    end

    always_comb begin
        sizes = '0;
        for (int unsigned i = 0; i < NUM_BALLS; i++)
            sizes[2*i +: 2] = size_q[i];
    end

    // Each load is registered by the cycle that decides it: split loads land during
    // SPLIT_A/SPLIT_B, the spawn load lands the cycle after SPAWN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.loadValid  <= 1'b0;
            bus.loadIdx    <= '0;
            bus.loadX      <= '0;
            bus.loadY      <= '0;
            bus.loadXSpeed <= '0;
            bus.loadYSpeed <= '0;
            active         <= '0;
            for (int unsigned i = 0; i < NUM_BALLS; i++)
                size_q[i] <= '0;
            hit_idx_q      <= '0;
            hit_x_q        <= '0;
            hit_y_q        <= '0;
            child_size_q   <= '0;
            free_found_q   <= 1'b0;
            free_idx_q     <= '0;
            frame_cnt      <= '0;
        end else begin
            bus.loadValid <= 1'b0;
            case (state)
                SPAWN: begin
                    bus.loadValid  <= 1'b1;
                    bus.loadIdx    <= '0;
                    bus.loadX      <= POS_W'(INITIAL_X);
                    bus.loadY      <= POS_W'(INITIAL_Y);
                    bus.loadXSpeed <= SPAWN_XS;
                    bus.loadYSpeed <= '0;
                    active[0]      <= 1'b1;
                    size_q[0]      <= ball_size_t'(MAX_SIZE);
                end
                IDLE: begin
                    if (hit_ok) begin
                        hit_idx_q    <= bus.hitIdx;
                        hit_x_q      <= bus.hitX;
                        hit_y_q      <= bus.hitY;
                        child_size_q <= hit_size - 2'd1;
                        free_found_q <= free_found;
                        free_idx_q   <= free_idx;
                        if (hit_size != '0) begin
                            bus.loadValid  <= 1'b1;
                            bus.loadIdx    <= bus.hitIdx;
                            bus.loadX      <= bus.hitX;
                            bus.loadY      <= bus.hitY;
                            bus.loadXSpeed <= LEFT_XS;
                            bus.loadYSpeed <= UP_YS;
                        end
                    end
                end
                SPLIT_A: begin
                    size_q[hit_idx_q] <= child_size_q;
                    if (free_found_q) begin
                        bus.loadValid  <= 1'b1;
                        bus.loadIdx    <= free_idx_q;
                        bus.loadX      <= hit_x_q;
                        bus.loadY      <= hit_y_q;
                        bus.loadXSpeed <= RIGHT_XS;
                        bus.loadYSpeed <= UP_YS;
                    end
                end
                SPLIT_B: begin
                    if (free_found_q) begin
                        active[free_idx_q] <= 1'b1;
                        size_q[free_idx_q] <= child_size_q;
                    end
                end
                KILL: begin
                    active <= remaining;
                    if (remaining == '0)
                        frame_cnt <= '0;
                end
                WAIT: begin
                    if (startOfFrame)
                        frame_cnt <= last_frame ? '0 : frame_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
